// File: rtl/regfile_sb.sv
// Scoreboarded register file: two combinational read ports (optional write bypass), two
// prioritised write ports, per-register busy bits, registered debug tap. No backpressure.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DBG_REG  = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   wa0,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd0,
  input  logic [XLEN-1:0] wd1,
  input  logic            wclr0,
  input  logic            wclr1,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_rd,
  output logic            busy1,
  output logic            busy2,
  output logic [NREG-1:0] busy_vec,
  output logic [XLEN-1:0] dbg_q
);

  localparam logic [AW-1:0] DBG_A = AW'(DBG_REG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] clr_vec;
  logic [XLEN-1:0] dbg_d;
  logic            wr0_ok;
  logic            wr1_ok;

  assign wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));

  // Port 1 is checked last so it overrides port 0 on an address collision.
  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] ra, input logic [XLEN-1:0] stored);
    logic [XLEN-1:0] r;
    r = stored;
    if (BYPASS != 0) begin
      if (we0 && (wa0 == ra)) r = wd0;
      if (we1 && (wa1 == ra)) r = wd1;
    end
    if ((ZERO_REG != 0) && (ra == '0)) r = '0;
    return r;
  endfunction

  assign rd1 = fwd(ra1, regs[ra1]);
  assign rd2 = fwd(ra2, regs[ra2]);

  always_comb begin
    clr_vec = '0;
    busy_d  = busy_q;
    for (int i = 0; i < NREG; i++) begin
      clr_vec[i] = (we0 && wclr0 && (wa0 == AW'(i))) || (we1 && wclr1 && (wa1 == AW'(i)));
      if (iss_v && (iss_rd == AW'(i))) busy_d[i] = 1'b1;
      else if (clr_vec[i])             busy_d[i] = 1'b0;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  assign busy1    = (BYPASS != 0) ? (busy_q[ra1] & ~clr_vec[ra1]) : busy_q[ra1];
  assign busy2    = (BYPASS != 0) ? (busy_q[ra2] & ~clr_vec[ra2]) : busy_q[ra2];
  assign busy_vec = busy_q;

  // The tap captures the value the register holds after this edge's write.
  always_comb begin
    dbg_d = regs[DBG_A];
    if (we0 && (wa0 == DBG_A)) dbg_d = wd0;
    if (we1 && (wa1 == DBG_A)) dbg_d = wd1;
    if ((ZERO_REG != 0) && (DBG_A == '0)) dbg_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy_q <= '0;
      dbg_q  <= '0;
    end else begin
      if (wr0_ok) regs[wa0] <= wd0;
      if (wr1_ok) regs[wa1] <= wd1;
      busy_q <= busy_d;
      dbg_q  <= dbg_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ra1, ra2, wa0, wa1, iss_rd;
  logic        we0, we1, wclr0, wclr1, iss_v;
  logic [31:0] wd0, wd1;
  logic [31:0] a_rd1, a_rd2, a_dbg, b_rd1, b_rd2, b_dbg;
  logic        a_busy1, a_busy2, b_busy1, b_busy2;
  logic [31:0] a_bvec, b_bvec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .wclr0(wclr0), .wclr1(wclr1), .iss_v(iss_v), .iss_rd(iss_rd),
    .busy1(a_busy1), .busy2(a_busy2), .busy_vec(a_bvec), .dbg_q(a_dbg)
  );

  regfile_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .wclr0(wclr0), .wclr1(wclr1), .iss_v(iss_v), .iss_rd(iss_rd),
    .busy1(b_busy1), .busy2(b_busy2), .busy_vec(b_bvec), .dbg_q(b_dbg)
  );

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed %h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; wclr0 = 0; wclr1 = 0; iss_v = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_rd = 0;
  endtask

  initial begin
    idle();
    ra1 = 5; ra2 = 0;
    #1 rst = 1;
    #1;
    expect_val("rst_rd1", 32'h0);     chk(a_rd1);
    expect_val("rst_rd2", 32'h0);     chk(a_rd2);
    expect_val("rst_busy_vec", 32'h0); chk(a_bvec);
    expect_val("rst_dbg", 32'h0);     chk(a_dbg);
    expect_val("rst_busy1", 32'h0);   chk({31'b0, a_busy1});
    tick(); rst = 0;

    // write x3, read it back, then reset mid-stream
    we0 = 1; wa0 = 3; wd0 = 32'hDEAD;
    tick(); idle(); ra1 = 3; #1;
    expect_val("x3_written_a", 32'hDEAD); chk(a_rd1);
    expect_val("x3_written_b", 32'hDEAD); chk(b_rd1);
    rst = 1; #1;
    expect_val("x3_after_rst_a", 32'h0); chk(a_rd1);
    expect_val("x3_after_rst_b", 32'h0); chk(b_rd1);
    tick(); rst = 0;

    // dual write same address: port 1 wins, bypass vs no bypass
    we0 = 1; wa0 = 7; wd0 = 32'h1111;
    we1 = 1; wa1 = 7; wd1 = 32'h2222;
    ra1 = 7; #1;
    expect_val("collide_bypass_rd1", 32'h2222); chk(a_rd1);
    expect_val("collide_nobypass_rd1", 32'h0); chk(b_rd1);
    tick(); idle(); #1;
    expect_val("collide_stored_a", 32'h2222); chk(a_rd1);
    expect_val("collide_stored_b", 32'h2222); chk(b_rd1);

    // x0 is hardwired
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; iss_v = 1; iss_rd = 0; ra1 = 0; #1;
    expect_val("x0_bypass_rd1", 32'h0); chk(a_rd1);
    tick(); idle(); #1;
    expect_val("x0_rd1", 32'h0); chk(a_rd1);
    expect_val("x0_busy", 32'h0); chk({31'b0, a_bvec[0]});

    // issue then clearing writeback
    iss_v = 1; iss_rd = 4;
    tick(); idle(); ra1 = 4; #1;
    expect_val("x4_busy_vec_set", 32'h1); chk({31'b0, a_bvec[4]});
    expect_val("x4_busy1_set", 32'h1); chk({31'b0, a_busy1});
    we1 = 1; wclr1 = 1; wa1 = 4; wd1 = 32'h55; #1;
    expect_val("x4_busy1_clr_bypass", 32'h0); chk({31'b0, a_busy1});
    expect_val("x4_rd1_bypass", 32'h55); chk(a_rd1);
    expect_val("x4_busy1_clr_nobypass", 32'h1); chk({31'b0, b_busy1});
    tick(); idle(); #1;
    expect_val("x4_busy_vec_clr_a", 32'h0); chk({31'b0, a_bvec[4]});
    expect_val("x4_busy_vec_clr_b", 32'h0); chk({31'b0, b_bvec[4]});

    // set beats simultaneous clear; data-only write keeps busy
    iss_v = 1; iss_rd = 9;
    tick(); idle();
    iss_v = 1; iss_rd = 9; we0 = 1; wclr0 = 1; wa0 = 9; wd0 = 32'h99;
    tick(); idle(); #1;
    expect_val("x9_set_wins", 32'h1); chk({31'b0, a_bvec[9]});
    we1 = 1; wa1 = 9; wd1 = 32'h77; ra2 = 9; #1;
    expect_val("x9_busy2_dataonly", 32'h1); chk({31'b0, a_busy2});
    tick(); idle(); #1;
    expect_val("x9_busy_kept", 32'h1); chk({31'b0, a_bvec[9]});
    expect_val("x9_rd2", 32'h77); chk(a_rd2);
    expect_val("busy_vec_full", 32'h0000_0200); chk(a_bvec);

    // debug tap on x10
    we0 = 1; wa0 = 10; wd0 = 32'hABCD; #1;
    expect_val("dbg_before_edge", 32'h0); chk(a_dbg);
    tick(); idle(); #1;
    expect_val("dbg_after_edge_a", 32'hABCD); chk(a_dbg);
    expect_val("dbg_after_edge_b", 32'hABCD); chk(b_dbg);
    tick();
    expect_val("dbg_held", 32'hABCD); chk(a_dbg);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded integer register file for the pipelined core, replacing the fixed 32x32 single-write-port file. It provides two combinational read ports with optional write-to-read bypass and two write ports with fixed priority. A per-register busy (scoreboard) bit is set when an instruction issues and cleared at writeback, and a debug tap exposes one selectable register. It sits between decode/issue and the writeback stage.

## Interface
- XLEN, 32, data width in bits (>=8)
- NREG, 32, number of registers; power of two, 2..64
- AW, $clog2(NREG), address width (derived, not overridden)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and is never busy; 0: register 0 is ordinary
- BYPASS, 1, 1: same-cycle write data forwarded to read ports and busy status
- DBG_REG, 10, index driven on dbg_q

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  XLEN  read data
- we0, we1  in  1  write enables (port 1 = late writeback, higher priority)
- wa0, wa1  in  AW  write addresses
- wd0, wd1  in  XLEN  write data
- wclr0, wclr1  in  1  qualifies weN: also clear busy bit of waN
- iss_v  in  1  issue valid: mark iss_rd busy
- iss_rd  in  AW  destination being issued
- busy1, busy2  out  1  busy status of ra1 / ra2
- busy_vec  out  NREG  registered scoreboard bits
- dbg_q  out  XLEN  registered copy of register DBG_REG

## Operation
- Storage: NREG x XLEN flops; busy[NREG] flops.
- Write: on rising clk, weN=1 writes wdN to waN. If we0 and we1 target the same address, wd1 is stored. If ZERO_REG=1, writes to address 0 are discarded.
- Read: rdK = reg[raK]. If BYPASS=1 and an enabled write targets raK this cycle, rdK = that write data (port 1 over port 0). If ZERO_REG=1 and raK=0, rdK=0 regardless of bypass.
- Scoreboard, evaluated per address each cycle:
  - clr = (we0&wclr0&wa0==a) | (we1&wclr1&wa1==a)
  - set = iss_v & iss_rd==a
  - next busy = set ? 1 : clr ? 0 : busy. Set wins over a simultaneous clear.
  - If ZERO_REG=1, busy[0] stays 0 and an issue to address 0 is ignored.
- busyK: BYPASS=1 gives busy[raK] & ~clr(raK); BYPASS=0 gives busy[raK]. A same-cycle issue does not affect busyK.
- dbg_q: registered each cycle with the post-write value of reg[DBG_REG], so it shows the new value one cycle after the write.
- weN without wclrN updates data only; the busy bit is unchanged.

## Timing
- Reset (async assert, release synchronised externally): all registers 0, busy_vec=0, dbg_q=0. rd1/rd2 read 0 and busy1/busy2 read 0 while rst=1 and no write is presented. Writes and issues during rst are ignored.
- Reset mid-operation discards pending writes and busy bits; nothing is retained.
- Read latency: 0 cycles, combinational from raK, we*, wa*, wd*.
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Busy set latency: busy_vec bit asserts the cycle after iss_v.
- Busy clear latency: busyK deasserts in the same cycle as the clearing write when BYPASS=1; busy_vec bit deasserts the cycle after.
- dbg_q latency: 1 cycle after the write edge.
- No stall is generated internally; issue logic combines busy1/busy2.

## Test plan
- Reset then ra1=5, ra2=0 -> rd1=0, rd2=0, busy_vec=0, dbg_q=0. Assert rst mid-stream after writing x3=0xDEAD -> rd(x3)=0 immediately.
- we0=1, wa0=7, wd0=0x1111 and we1=1, wa1=7, wd1=0x2222 with ra1=7 -> rd1=0x2222 same cycle (BYPASS=1). Next cycle, with no write, rd1=0x2222.
- Write x0=0xFFFF_FFFF and issue iss_rd=0 -> rd1(ra1=0)=0 and busy_vec[0]=0 (ZERO_REG=1).
- iss_v with iss_rd=4, then we1=1, wclr1=1, wa1=4, wd1=0x55 with ra1=4 -> busy1=0 and rd1=0x55 that cycle; busy_vec[4]=0 next cycle.
- Same cycle: iss_v with iss_rd=9 while a clearing write targets x9, x9 previously busy -> busy_vec[9]=1 afterwards. A data-only write (wclr=0) to busy x9 -> busy_vec[9] stays 1.
- Write x10=0xABCD (DBG_REG=10) -> dbg_q=0 at the write edge, 0xABCD one cycle later. Rerun the bypass case with BYPASS=0 -> rd1 shows the old value in the write cycle.
